// File: rtl/ps2_pkg.sv
// Shared types and scancode constants for the PS/2 arrow-key decoder.
package ps2_pkg;

   // Frame receiver states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_e;

   // Prefix bytes: extended-key and break (key release).
   localparam logic [7:0] CODE_EXT   = 8'hE0;
   localparam logic [7:0] CODE_BRK   = 8'hF0;

   // Arrow-key make codes (identical with or without an E0 prefix).
   localparam logic [7:0] CODE_UP    = 8'h75;
   localparam logic [7:0] CODE_DOWN  = 8'h72;
   localparam logic [7:0] CODE_LEFT  = 8'h6B;
   localparam logic [7:0] CODE_RIGHT = 8'h74;

   // One-hot dir mask {up,down,left,right} for a scancode; zero for non-arrows.
   function automatic logic [3:0] arrow_mask(input logic [7:0] code);
      logic [3:0] mask;
      mask = 4'b0000;
      case (code)
         CODE_UP:    mask = 4'b1000;
         CODE_DOWN:  mask = 4'b0100;
         CODE_LEFT:  mask = 4'b0010;
         CODE_RIGHT: mask = 4'b0001;
         default:    mask = 4'b0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronises the raw PS/2 clock, debounces it and emits a falling-edge strobe.
module ps2_clk_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic fall
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // Two-flop synchroniser; idles high like the bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Level follows the synchronised input only after FILTER_LEN equal samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level <= 1'b1;
         cnt   <= '0;
         fall  <= 1'b0;
      end else begin
         fall <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER_LEN - 1)) begin
            level <= sync2;
            cnt   <= '0;
            fall  <= ~sync2;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver that tracks held arrow keys and reports make codes.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [3:0] dir,
   output logic [7:0] scancode,
   output logic       code_valid,
   output logic       frame_err,
   output ps2_state_e fsm_state
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          data_s1;
   logic          data_s2;
   logic          clk_level;
   logic          fall;

   ps2_state_e    state, state_next;
   logic [2:0]    bit_cnt, bit_cnt_next;
   logic [7:0]    shreg, shreg_next;
   logic          par, par_next;
   logic          ext_pending, ext_next;
   logic          brk_pending, brk_next;
   logic [3:0]    dir_next;
   logic [7:0]    code_next;
   logic          valid_next;
   logic          err_next;
   logic [TW-1:0] to_cnt, to_cnt_next;

   ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk   (clk),
      .rst   (rst),
      .raw   (ps2_clk),
      .level (clk_level),
      .fall  (fall)
   );

   // Data line only needs synchronising; it is sampled on filtered clock falls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_s1 <= 1'b1;
         data_s2 <= 1'b1;
      end else begin
         data_s1 <= ps2_data;
         data_s2 <= data_s1;
      end
   end

   // Register bank for the frame receiver and decoded outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         shreg       <= '0;
         par         <= 1'b0;
         ext_pending <= 1'b0;
         brk_pending <= 1'b0;
         dir         <= '0;
         scancode    <= '0;
         code_valid  <= 1'b0;
         frame_err   <= 1'b0;
         to_cnt      <= '0;
      end else begin
         state       <= state_next;
         bit_cnt     <= bit_cnt_next;
         shreg       <= shreg_next;
         par         <= par_next;
         ext_pending <= ext_next;
         brk_pending <= brk_next;
         dir         <= dir_next;
         scancode    <= code_next;
         code_valid  <= valid_next;
         frame_err   <= err_next;
         to_cnt      <= to_cnt_next;
      end
   end

   // Frame FSM, inactivity timeout and prefix/arrow decoding.
   always_comb begin
      state_next   = state;
      bit_cnt_next = bit_cnt;
      shreg_next   = shreg;
      par_next     = par;
      ext_next     = ext_pending;
      brk_next     = brk_pending;
      dir_next     = dir;
      code_next    = scancode;
      valid_next   = 1'b0;
      err_next     = 1'b0;
      to_cnt_next  = '0;

      if (fall) begin
         case (state)
            IDLE: begin
               if (!data_s2) begin
                  state_next   = DATA;
                  bit_cnt_next = '0;
               end
            end
            DATA: begin
               shreg_next   = {data_s2, shreg[7:1]};
               bit_cnt_next = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  state_next = PARITY;
               end
            end
            PARITY: begin
               par_next   = data_s2;
               state_next = STOP;
            end
            STOP: begin
               state_next = IDLE;
               if (data_s2 && ((^shreg) ^ par)) begin
                  if (shreg == CODE_EXT) begin
                     ext_next = 1'b1;
                  end else if (shreg == CODE_BRK) begin
                     brk_next = 1'b1;
                  end else begin
                     if (brk_pending) begin
                        dir_next = dir & ~arrow_mask(shreg);
                     end else begin
                        dir_next   = dir | arrow_mask(shreg);
                        code_next  = shreg;
                        valid_next = 1'b1;
                     end
                     ext_next = 1'b0;
                     brk_next = 1'b0;
                  end
               end else begin
                  err_next = 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end else if (state != IDLE) begin
         if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state_next   = IDLE;
            err_next     = 1'b1;
            bit_cnt_next = '0;
            shreg_next   = '0;
            ext_next     = 1'b0;
            brk_next     = 1'b0;
         end else begin
            to_cnt_next = to_cnt + TW'(1);
         end
      end
   end

   assign fsm_state = state;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomised scoreboard bench for the PS/2 arrow-key decoder.
module tb_ps2_key_decoder;
   import ps2_pkg::*;

   localparam int FL   = 8;
   localparam int TO   = 2000;
   localparam int HALF = 20;
   localparam int W    = 14;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [3:0] dir;
   logic [7:0] scancode;
   logic       code_valid;
   logic       frame_err;
   ps2_state_e fsm_state;

   int checks = 0;
   int errors = 0;

   // Expected pulse words: {code_valid, frame_err, scancode, dir}.
   logic [W-1:0] exp_q[$];

   // Reference model state.
   logic [3:0] m_dir;
   logic [7:0] m_code;
   bit         m_brk;
   bit         m_ext;
   logic [7:0] arrows[4] = '{8'h74, 8'h6B, 8'h72, 8'h75};

   ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .dir        (dir),
      .scancode   (scancode),
      .code_valid (code_valid),
      .frame_err  (frame_err),
      .fsm_state  (fsm_state)
   );

   // Clock.
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic model_reset();
      m_dir  = '0;
      m_code = '0;
      m_brk  = 0;
      m_ext  = 0;
   endtask

   // Keyboard semantics: prefixes arm flags, makes press, breaks release.
   task automatic model_byte(input logic [7:0] b, input bit good);
      int idx;
      if (!good) begin
         exp_q.push_back({1'b0, 1'b1, m_code, m_dir});
         return;
      end
      if (b == 8'hE0) begin
         m_ext = 1;
      end else if (b == 8'hF0) begin
         m_brk = 1;
      end else begin
         idx = -1;
         for (int i = 0; i < 4; i++) if (arrows[i] == b) idx = i;
         if (!m_brk) begin
            m_code = b;
            if (idx >= 0) m_dir[idx] = 1'b1;
            exp_q.push_back({1'b1, 1'b0, m_code, m_dir});
         end else if (idx >= 0) begin
            m_dir[idx] = 1'b0;
         end
         m_brk = 0;
         m_ext = 0;
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
   endtask

   // Waits (bounded) for every expected pulse, then compares held outputs.
   task automatic settle(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         wait_cycles(1);
         n++;
      end
      if (exp_q.size() != 0) begin
         check({tag, "_pulse_missing"}, 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      check({tag, "_dir"}, 32'(dir), 32'(m_dir));
      check({tag, "_scancode"}, 32'(scancode), 32'(m_code));
   endtask

   task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop_bit);
      logic p;
      model_byte(b, !par_flip && stop_bit);
      p = (~^b) ^ par_flip;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(p);
      send_bit(stop_bit);
      ps2_data = 1'b1;
      wait_cycles(HALF);
   endtask

   task automatic send_raw_frame(input logic [7:0] b, input logic p);
      model_byte(b, ((^b) ^ p) == 1'b1);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(p);
      send_bit(1'b1);
      ps2_data = 1'b1;
      wait_cycles(HALF);
   endtask

   // Monitor: every output pulse must match the head of the expected queue.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && (code_valid === 1'b1 || frame_err === 1'b1)) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse: got %h expected no pulse",
                        {code_valid, frame_err, scancode, dir});
            end else begin
               check("pulse", 32'({code_valid, frame_err, scancode, dir}), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   // Driver.
   initial begin
      logic [7:0] pool[7] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'hE0, 8'hF0, 8'h1C};
      logic [7:0] b;
      model_reset();
      #1 rst = 1'b1;
      wait_cycles(5);
      rst = 1'b0;
      wait_cycles(5);
      check("reset_dir", 32'(dir), 32'd0);
      check("reset_scancode", 32'(scancode), 32'd0);
      check("reset_pulses", 32'({code_valid, frame_err}), 32'd0);
      check("reset_state", 32'(fsm_state), 32'(IDLE));

      // Single up-arrow make.
      send_frame(8'h75, 0, 1);
      settle("up_make");
      check("up_dir_value", 32'(dir), 32'h8);

      // Release up, then extended left press and release.
      send_frame(8'hF0, 0, 1);
      send_frame(8'h75, 0, 1);
      settle("up_break");
      send_frame(8'hE0, 0, 1);
      send_frame(8'h6B, 0, 1);
      settle("ext_left_make");
      check("left_dir_value", 32'(dir), 32'h2);
      send_frame(8'hE0, 0, 1);
      send_frame(8'hF0, 0, 1);
      send_frame(8'h6B, 0, 1);
      settle("ext_left_break");
      check("left_released", 32'(dir), 32'h0);

      // Right arrow with a bad parity bit is rejected.
      send_raw_frame(8'h74, 1'b0);
      settle("bad_parity");

      // Bad stop bit is rejected.
      send_frame(8'h72, 0, 0);
      settle("bad_stop");

      // Truncated frame followed by silence times out.
      exp_q.push_back({1'b0, 1'b1, m_code, m_dir});
      m_brk = 0;
      m_ext = 0;
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
      ps2_data = 1'b1;
      wait_cycles(TO + TO / 5);
      settle("timeout");
      check("timeout_state", 32'(fsm_state), 32'(IDLE));
      send_frame(8'h72, 0, 1);
      settle("after_timeout");
      check("down_dir_value", 32'(dir), 32'h4);

      // Short glitches on the clock line while idle must be ignored.
      for (int k = 0; k < 5; k++) begin
         ps2_clk = 1'b0;
         wait_cycles(3);
         ps2_clk = 1'b1;
         wait_cycles($urandom_range(10, 30));
      end
      settle("glitch");
      check("glitch_state", 32'(fsm_state), 32'(IDLE));

      // Typematic repeat keeps the bit and pulses again.
      send_frame(8'h72, 0, 1);
      send_frame(8'h72, 0, 1);
      settle("typematic");

      // Randomised traffic including errors.
      for (int n = 0; n < 40; n++) begin
         b = pool[$urandom_range(0, 6)];
         if ($urandom_range(0, 5) == 0) b = 8'($urandom_range(0, 255));
         send_frame(b, $urandom_range(0, 7) == 0, $urandom_range(0, 11) != 0);
         settle("random");
      end

      // Hold left and up, then reset in the middle of a down frame.
      send_frame(8'h6B, 0, 1);
      send_frame(8'h75, 0, 1);
      settle("pre_reset");
      b = 8'h72;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(b[i]);
      #3 rst = 1'b1;
      #2;
      check("rst_dir", 32'(dir), 32'd0);
      check("rst_scancode", 32'(scancode), 32'd0);
      check("rst_pulses", 32'({code_valid, frame_err}), 32'd0);
      check("rst_state", 32'(fsm_state), 32'(IDLE));
      model_reset();
      exp_q.delete();
      ps2_data = 1'b1;
      wait_cycles(4);
      rst = 1'b0;
      wait_cycles(10);
      send_frame(8'h72, 0, 1);
      settle("post_reset");
      check("post_reset_dir_value", 32'(dir), 32'h4);

      wait_cycles(20);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
